// File: rtl/pwr_dom_seq26.sv
// Power-domain sequencer: one shared FSM walks one domain at a time through
// shutdown (clock gate, isolate, save, power off) or wake-up (power on, restore, release).
module pwr_dom_seq26 #(
  parameter int NDOM = 4,
  parameter int CNTW = 6
) (
  input  logic            pclk26,
  input  logic            nprst26,
  input  logic [NDOM-1:0] L1_req,
  input  logic [CNTW-1:0] stab_cnt,
  output logic [NDOM-1:0] gate_clk,
  output logic [NDOM-1:0] isolate,
  output logic [NDOM-1:0] rstn_non_srpg,
  output logic [NDOM-1:0] save_edge,
  output logic [NDOM-1:0] restore_edge,
  output logic [NDOM-1:0] pwr1_on,
  output logic [NDOM-1:0] pwr2_on,
  output logic [NDOM-1:0] set_status,
  output logic [NDOM-1:0] clr_status,
  output logic            busy,
  output logic [2:0]      cur_dom,
  output logic [3:0]      dbg_state
);

  typedef enum logic [3:0] {
    IDLE, CLK_OFF, WAIT1, ISOLATE, SAVE, PRE_OFF, PWR_OFF, PWR_ON1,
    PWR_ON2, RESTORE, WAIT2, DE_ISO, CLK_ON, WAIT3, RST_CLR
  } state_t;

  state_t          state, state_nxt;
  logic [NDOM-1:0] off;
  logic [2:0]      last_srv;
  logic [CNTW-1:0] cnt;
  logic [7:0]      pend8, off8;
  logic [3:0]      idx;
  logic [2:0]      sel;
  logic            found;
  logic [NDOM-1:0] rstn_d;

  assign dbg_state = state;
  assign busy      = (state != IDLE);

  // A domain is pending whenever its committed state disagrees with its request.
  always_comb begin
    pend8 = '0;
    off8  = '0;
    pend8[NDOM-1:0] = off ^ L1_req;
    off8[NDOM-1:0]  = off;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    // Descending scan so the smallest round-robin offset wins.
    for (int k = NDOM - 1; k >= 0; k--) begin
      idx = {1'b0, last_srv} + 4'd1 + 4'(k);
      if (idx >= 4'(NDOM)) idx = idx - 4'(NDOM);
      if (pend8[idx[2:0]]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = off8[sel] ? PWR_ON1 : CLK_OFF;
      CLK_OFF: state_nxt = WAIT1;
      WAIT1:   state_nxt = ISOLATE;
      ISOLATE: state_nxt = SAVE;
      SAVE:    state_nxt = PRE_OFF;
      PRE_OFF: state_nxt = PWR_OFF;
      PWR_OFF: state_nxt = IDLE;
      PWR_ON1: state_nxt = PWR_ON2;
      PWR_ON2: if (cnt == '0) state_nxt = RESTORE;
      RESTORE: state_nxt = WAIT2;
      WAIT2:   state_nxt = DE_ISO;
      DE_ISO:  state_nxt = CLK_ON;
      CLK_ON:  state_nxt = WAIT3;
      WAIT3:   state_nxt = RST_CLR;
      RST_CLR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk26 or negedge nprst26) begin
    if (!nprst26) begin
      state    <= IDLE;
      off      <= '0;
      cur_dom  <= '0;
      last_srv <= 3'(NDOM - 1);
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        cur_dom  <= sel;
        last_srv <= sel;
        if (off8[sel]) cnt <= stab_cnt;
      end
      if (state == PWR_ON2 && cnt != '0) cnt <= cnt - 1'b1;
      for (int i = 0; i < NDOM; i++) begin
        if (cur_dom == 3'(i) && state == PWR_OFF) off[i] <= 1'b1;
        if (cur_dom == 3'(i) && state == RST_CLR) off[i] <= 1'b0;
      end
    end
  end

  // Idle domains mirror their off flag; the active domain follows the state table.
  always_comb begin
    gate_clk     = '0;
    isolate      = '0;
    rstn_d       = '1;
    save_edge    = '0;
    restore_edge = '0;
    pwr1_on      = '1;
    pwr2_on      = '1;
    set_status   = '0;
    clr_status   = '0;
    for (int i = 0; i < NDOM; i++) begin
      gate_clk[i] = off[i];
      isolate[i]  = off[i];
      rstn_d[i]   = ~off[i];
      pwr1_on[i]  = ~off[i];
      pwr2_on[i]  = ~off[i];
      if (busy && cur_dom == 3'(i)) begin
        case (state)
          CLK_OFF: begin gate_clk[i] = 1'b1; isolate[i] = 1'b0; rstn_d[i] = 1'b1;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; set_status[i] = 1'b1; end
          WAIT1:   begin gate_clk[i] = 1'b1; isolate[i] = 1'b0; rstn_d[i] = 1'b1;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; end
          ISOLATE, PRE_OFF:
                   begin gate_clk[i] = 1'b1; isolate[i] = 1'b1; rstn_d[i] = 1'b1;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; end
          SAVE:    begin gate_clk[i] = 1'b1; isolate[i] = 1'b1; rstn_d[i] = 1'b1;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; save_edge[i] = 1'b1; end
          PWR_OFF: begin gate_clk[i] = 1'b1; isolate[i] = 1'b1; rstn_d[i] = 1'b0;
                         pwr1_on[i] = 1'b0; pwr2_on[i] = 1'b0; end
          PWR_ON1: begin gate_clk[i] = 1'b1; isolate[i] = 1'b1; rstn_d[i] = 1'b0;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b0; end
          PWR_ON2, WAIT2:
                   begin gate_clk[i] = 1'b1; isolate[i] = 1'b1; rstn_d[i] = 1'b0;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; end
          RESTORE: begin gate_clk[i] = 1'b1; isolate[i] = 1'b1; rstn_d[i] = 1'b0;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; restore_edge[i] = 1'b1; end
          DE_ISO:  begin gate_clk[i] = 1'b1; isolate[i] = 1'b0; rstn_d[i] = 1'b0;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; end
          CLK_ON, WAIT3:
                   begin gate_clk[i] = 1'b0; isolate[i] = 1'b0; rstn_d[i] = 1'b0;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; end
          RST_CLR: begin gate_clk[i] = 1'b0; isolate[i] = 1'b0; rstn_d[i] = 1'b1;
                         pwr1_on[i] = 1'b1; pwr2_on[i] = 1'b1; clr_status[i] = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  assign rstn_non_srpg = rstn_d & {NDOM{nprst26}};

endmodule

// File: tb/tb_pwr_dom_seq26.sv
// Directed bench for pwr_dom_seq26 (NDOM=4, CNTW=6): one task per scenario,
// hand-derived expected values, summary line at the end.
module tb_pwr_dom_seq26;
  localparam int NDOM = 4;
  localparam int CNTW = 6;

  logic            pclk26 = 1'b0;
  logic            nprst26 = 1'b0;
  logic [NDOM-1:0] L1_req = '0;
  logic [CNTW-1:0] stab_cnt = '0;
  logic [NDOM-1:0] gate_clk, isolate, rstn_non_srpg, save_edge, restore_edge;
  logic [NDOM-1:0] pwr1_on, pwr2_on, set_status, clr_status;
  logic            busy;
  logic [2:0]      cur_dom;
  logic [3:0]      dbg_state;

  int pass_cnt = 0;
  int total = 0;
  logic [2:0] exp_q[$];

  pwr_dom_seq26 #(.NDOM(NDOM), .CNTW(CNTW)) dut (
    .pclk26(pclk26), .nprst26(nprst26), .L1_req(L1_req), .stab_cnt(stab_cnt),
    .gate_clk(gate_clk), .isolate(isolate), .rstn_non_srpg(rstn_non_srpg),
    .save_edge(save_edge), .restore_edge(restore_edge), .pwr1_on(pwr1_on),
    .pwr2_on(pwr2_on), .set_status(set_status), .clr_status(clr_status),
    .busy(busy), .cur_dom(cur_dom), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 pclk26 = ~pclk26;

  task automatic tick();
    @(posedge pclk26);
    #1;
  endtask

  task automatic do_reset();
    nprst26 = 1'b0;
    tick();
    tick();
    nprst26 = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 300);
    total++;
    if (busy !== 1'b0) $display("FAIL wait_idle_timeout: busy=%b after %0d cycles exp 0", busy, n);
    else pass_cnt++;
  endtask

  // counts PWR_ON2 cycles of domain 0: called on the PWR_ON1 cycle, stops at restore_edge
  task automatic on2_len(output int n);
    n = 0;
    tick();
    while (restore_edge[0] !== 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (gate_clk !== 4'b0000) $display("FAIL rst_gate: got %b exp 0000", gate_clk); else pass_cnt++;
    total++; if (isolate !== 4'b0000) $display("FAIL rst_iso: got %b exp 0000", isolate); else pass_cnt++;
    total++; if (rstn_non_srpg !== 4'b0000) $display("FAIL rst_rstn: got %b exp 0000", rstn_non_srpg); else pass_cnt++;
    total++; if ({pwr1_on, pwr2_on} !== 8'hFF) $display("FAIL rst_pwr: got %b %b exp 1111 1111", pwr1_on, pwr2_on); else pass_cnt++;
    total++; if ({save_edge, restore_edge, set_status, clr_status} !== 16'h0) $display("FAIL rst_pulses: got %h exp 0", {save_edge, restore_edge, set_status, clr_status}); else pass_cnt++;
    total++; if ({busy, cur_dom} !== 4'b0000) $display("FAIL rst_busy_dom: got %b exp 0000", {busy, cur_dom}); else pass_cnt++;
    tick();
    nprst26 = 1'b1;
    tick();
    total++; if (rstn_non_srpg !== 4'b1111) $display("FAIL rst_release_rstn: got %b exp 1111", rstn_non_srpg); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_shutdown();
    L1_req = 4'b0001;
    tick(); // CLK_OFF
    total++; if (set_status !== 4'b0001) $display("FAIL sd_set_status: got %b exp 0001", set_status); else pass_cnt++;
    total++; if ({busy, cur_dom} !== 4'b1000) $display("FAIL sd_busy_dom: got %b exp 1000", {busy, cur_dom}); else pass_cnt++;
    total++; if ({gate_clk, isolate} !== 8'b0001_0000) $display("FAIL sd_clk_off: got %b exp 00010000", {gate_clk, isolate}); else pass_cnt++;
    tick(); // WAIT1
    total++; if (set_status !== 4'b0000) $display("FAIL sd_set_once: got %b exp 0000", set_status); else pass_cnt++;
    tick(); // ISOLATE
    total++; if (isolate !== 4'b0001) $display("FAIL sd_isolate: got %b exp 0001", isolate); else pass_cnt++;
    tick(); // SAVE
    total++; if (save_edge !== 4'b0001) $display("FAIL sd_save: got %b exp 0001", save_edge); else pass_cnt++;
    tick(); // PRE_OFF
    total++; if ({save_edge, pwr1_on} !== 8'b0000_1111) $display("FAIL sd_pre_off: got %b exp 00001111", {save_edge, pwr1_on}); else pass_cnt++;
    tick(); // PWR_OFF
    total++; if ({pwr1_on, pwr2_on, rstn_non_srpg} !== 12'b1110_1110_1110) $display("FAIL sd_pwr_off: got %b exp 111011101110", {pwr1_on, pwr2_on, rstn_non_srpg}); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL sd_busy6: got %b exp 1", busy); else pass_cnt++;
    tick(); // IDLE, domain 0 held off
    total++; if (busy !== 1'b0) $display("FAIL sd_idle: got %b exp 0", busy); else pass_cnt++;
    total++; if ({gate_clk, isolate, rstn_non_srpg, pwr1_on, pwr2_on} !== 20'b0001_0001_1110_1110_1110) $display("FAIL sd_hold_off: got %b exp 00010001111011101110", {gate_clk, isolate, rstn_non_srpg, pwr1_on, pwr2_on}); else pass_cnt++;
  endtask

  task automatic test_wake();
    int n;
    stab_cnt = 6'd5;
    L1_req = 4'b0000;
    tick(); // PWR_ON1
    stab_cnt = 6'd0; // must not affect the count already loaded
    total++; if ({busy, pwr1_on[0], pwr2_on[0], isolate[0]} !== 4'b1101) $display("FAIL wk_pwr_on1: got %b exp 1101", {busy, pwr1_on[0], pwr2_on[0], isolate[0]}); else pass_cnt++;
    on2_len(n);
    total++; if (n !== 6) $display("FAIL wk_on2_len: got %0d exp 6", n); else pass_cnt++;
    total++; if ({restore_edge, isolate, gate_clk} !== 12'b0001_0001_0001) $display("FAIL wk_restore: got %b exp 000100010001", {restore_edge, isolate, gate_clk}); else pass_cnt++;
    tick(); // WAIT2
    tick(); // DE_ISO
    total++; if ({isolate[0], gate_clk[0], rstn_non_srpg[0]} !== 3'b010) $display("FAIL wk_de_iso: got %b exp 010", {isolate[0], gate_clk[0], rstn_non_srpg[0]}); else pass_cnt++;
    tick(); // CLK_ON
    total++; if ({gate_clk[0], rstn_non_srpg[0]} !== 2'b00) $display("FAIL wk_clk_on: got %b exp 00", {gate_clk[0], rstn_non_srpg[0]}); else pass_cnt++;
    tick(); // WAIT3
    tick(); // RST_CLR
    total++; if ({clr_status, rstn_non_srpg} !== 8'b0001_1111) $display("FAIL wk_clr_status: got %b exp 00011111", {clr_status, rstn_non_srpg}); else pass_cnt++;
    tick(); // IDLE
    total++; if ({busy, clr_status, gate_clk} !== 9'b0) $display("FAIL wk_idle: got %b exp 000000000", {busy, clr_status, gate_clk}); else pass_cnt++;
  endtask

  task automatic test_stab_bounds();
    int n;
    int m;
    L1_req = 4'b0001;
    wait_idle(m);
    stab_cnt = 6'd0;
    L1_req = 4'b0000;
    tick(); // PWR_ON1
    on2_len(n);
    total++; if (n !== 1) $display("FAIL stab0_len: got %0d exp 1", n); else pass_cnt++;
    wait_idle(m);
    L1_req = 4'b0001;
    wait_idle(m);
    stab_cnt = 6'd63;
    L1_req = 4'b0000;
    tick();
    on2_len(n);
    total++; if (n !== 64) $display("FAIL stab63_len: got %0d exp 64", n); else pass_cnt++;
    wait_idle(m);
    total++; if (pwr1_on !== 4'b1111) $display("FAIL stab_final_on: got %b exp 1111", pwr1_on); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [2:0] got_q[$];
    logic overlap;
    logic [2:0] e;
    do_reset();
    overlap = 1'b0;
    L1_req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      tick();
      if ((set_status & clr_status) != 0) overlap = 1'b1;
      for (int i = 0; i < NDOM; i++) if (set_status[i]) got_q.push_back(3'(i));
    end
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    total++; if (got_q.size() !== 4) $display("FAIL rr_sd_count: got %0d exp 4", got_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (got_q[0] !== e) $display("FAIL rr_sd_order: got %0d exp %0d", got_q[0], e); else pass_cnt++;
      void'(got_q.pop_front());
    end
    total++; if ({busy, pwr1_on, isolate} !== 9'b0_0000_1111) $display("FAIL rr_all_off: got %b exp 000001111", {busy, pwr1_on, isolate}); else pass_cnt++;
    got_q.delete();
    stab_cnt = 6'd2;
    L1_req = 4'b0000;
    for (int c = 0; c < 80; c++) begin
      tick();
      if ((set_status & clr_status) != 0) overlap = 1'b1;
      for (int i = 0; i < NDOM; i++) if (clr_status[i]) got_q.push_back(3'(i));
    end
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    total++; if (got_q.size() !== 4) $display("FAIL rr_wk_count: got %0d exp 4", got_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (got_q[0] !== e) $display("FAIL rr_wk_order: got %0d exp %0d", got_q[0], e); else pass_cnt++;
      void'(got_q.pop_front());
    end
    total++; if (overlap !== 1'b0) $display("FAIL rr_set_clr_overlap: got %b exp 0", overlap); else pass_cnt++;
    total++; if ({busy, pwr1_on, gate_clk} !== 9'b0_1111_0000) $display("FAIL rr_all_on: got %b exp 011110000", {busy, pwr1_on, gate_clk}); else pass_cnt++;
  endtask

  task automatic test_toggle_mid();
    int m;
    do_reset();
    stab_cnt = 6'd1;
    L1_req = 4'b0001;
    tick(); // CLK_OFF
    tick(); // WAIT1
    tick(); // ISOLATE
    total++; if (isolate !== 4'b0001) $display("FAIL tg_isolate: got %b exp 0001", isolate); else pass_cnt++;
    L1_req = 4'b0000;
    tick(); // SAVE
    total++; if ({busy, save_edge} !== 5'b1_0001) $display("FAIL tg_save: got %b exp 10001", {busy, save_edge}); else pass_cnt++;
    tick(); // PRE_OFF
    tick(); // PWR_OFF
    total++; if (pwr1_on !== 4'b1110) $display("FAIL tg_pwr_off: got %b exp 1110", pwr1_on); else pass_cnt++;
    tick(); // IDLE
    total++; if (busy !== 1'b0) $display("FAIL tg_idle: got %b exp 0", busy); else pass_cnt++;
    tick(); // PWR_ON1
    total++; if ({busy, pwr1_on[0], pwr2_on[0]} !== 3'b110) $display("FAIL tg_wake_start: got %b exp 110", {busy, pwr1_on[0], pwr2_on[0]}); else pass_cnt++;
    wait_idle(m);
    total++; if ({pwr1_on, gate_clk} !== 8'b1111_0000) $display("FAIL tg_woken: got %b exp 11110000", {pwr1_on, gate_clk}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int m;
    logic [NDOM-1:0] pulses;
    L1_req = 4'b0001;
    wait_idle(m);
    stab_cnt = 6'd20;
    L1_req = 4'b0000;
    tick(); // PWR_ON1
    tick(); // PWR_ON2
    tick();
    nprst26 = 1'b0;
    #1;
    total++; if ({gate_clk, isolate, rstn_non_srpg} !== 12'b0) $display("FAIL rm_async_ctl: got %b exp 000000000000", {gate_clk, isolate, rstn_non_srpg}); else pass_cnt++;
    total++; if ({pwr1_on, pwr2_on} !== 8'hFF) $display("FAIL rm_async_pwr: got %b exp 11111111", {pwr1_on, pwr2_on}); else pass_cnt++;
    total++; if ({busy, restore_edge} !== 5'b0) $display("FAIL rm_async_busy: got %b exp 00000", {busy, restore_edge}); else pass_cnt++;
    tick();
    nprst26 = 1'b1;
    pulses = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      pulses = pulses | save_edge | restore_edge | set_status | clr_status;
    end
    total++; if (pulses !== 4'b0000) $display("FAIL rm_no_pulse: got %b exp 0000", pulses); else pass_cnt++;
    total++; if ({busy, gate_clk, rstn_non_srpg} !== 9'b0_0000_1111) $display("FAIL rm_off_cleared: got %b exp 000001111", {busy, gate_clk, rstn_non_srpg}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_shutdown();
    test_wake();
    test_stab_bounds();
    test_round_robin();
    test_toggle_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total);
    $fatal(1);
  end
endmodule
